// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with row synchronizer and tick-based debounce.
// Presents a stable {column,row} code pair plus press/held status to kpdecode.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpr_in,
    output logic [3:0] kpc,
    output logic [3:0] kpc_q,
    output logic [3:0] kpr_q,
    output logic       press,
    output logic       held
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] presc;
    logic          tick;
    logic [3:0]    sync1, rows_s;
    logic [3:0]    cand, cand_next;
    logic [CW-1:0] cnt, cnt_next, cnt_inc;
    logic [3:0]    kpc_next, kpc_q_next, kpr_q_next, rotated;
    logic          held_next, press_next, row_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            sync1  <= kpr_in;
            rows_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            presc <= '0;
        else if (presc == PRESC_LAST)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    assign tick    = (presc == PRESC_LAST);
    assign cnt_inc = cnt + CW'(1);
    assign rotated = {kpc[0], kpc[3:1]};

    always_comb begin
        row_valid = 1'b0;
        case (rows_s)
            4'h7, 4'hB, 4'hD, 4'hE: row_valid = 1'b1;
            default:                row_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCAN;
            cand  <= 4'hF;
            cnt   <= '0;
            kpc   <= 4'b0111;
            kpc_q <= 4'b0111;
            kpr_q <= 4'hF;
            held  <= 1'b0;
            press <= 1'b0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            cnt   <= cnt_next;
            kpc   <= kpc_next;
            kpc_q <= kpc_q_next;
            kpr_q <= kpr_q_next;
            held  <= held_next;
            press <= press_next;
        end
    end

    // All decisions are gated by tick, so kpc always has a full scan period to settle
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        kpc_next   = kpc;
        kpc_q_next = kpc_q;
        kpr_q_next = kpr_q;
        held_next  = held;
        press_next = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_valid) begin
                        cand_next  = rows_s;
                        cnt_next   = CW'(1);
                        state_next = DEBOUNCE;
                    end else begin
                        kpc_next = rotated;
                    end
                end
                DEBOUNCE: begin
                    if (rows_s == cand) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_next = HELD;
                            kpr_q_next = cand;
                            kpc_q_next = kpc;
                            held_next  = 1'b1;
                            press_next = 1'b1;
                        end
                    end else begin
                        state_next = SCAN;
                        cnt_next   = '0;
                        kpc_next   = rotated;
                    end
                end
                HELD: begin
                    if (rows_s != kpr_q) begin
                        state_next = RELEASE;
                        cnt_next   = CW'(1);
                    end
                end
                RELEASE: begin
                    if (rows_s == 4'hF) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_next = SCAN;
                            kpr_q_next = 4'hF;
                            held_next  = 1'b0;
                            cnt_next   = '0;
                            kpc_next   = rotated;
                        end
                    end else if (rows_s == kpr_q) begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = '0;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3 and a simple
// keypad model: the pressed key's row goes low only while its column is driven.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] kpr_in;
    logic [3:0] kpc, kpc_q, kpr_q;
    logic       press, held;

    logic       key_down   = 1'b0;
    logic [3:0] key_col    = 4'hB;
    logic [3:0] key_row    = 4'hB;
    logic       force_en   = 1'b0;
    logic [3:0] force_rows = 4'hF;

    int errors = 0;
    int checks = 0;

    logic [3:0] seq [4] = '{4'h7, 4'hB, 4'hD, 4'hE};

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kpr_in  (kpr_in),
        .kpc     (kpc),
        .kpc_q   (kpc_q),
        .kpr_q   (kpr_q),
        .press   (press),
        .held    (held)
    );

    always #5 clk = ~clk;

    assign kpr_in = force_en ? force_rows :
                    ((key_down && (kpc == key_col)) ? key_row : 4'hF);

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    initial begin
        // 1: reset values, then free scan with no key
        step(1);
        check("rst_kpc", kpc, 4'h7);
        check("rst_kpc_q", kpc_q, 4'h7);
        check("rst_kpr_q", kpr_q, 4'hF);
        check("rst_press", {3'b0, press}, 4'h0);
        check("rst_held", {3'b0, held}, 4'h0);
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check("scan_kpc", kpc, seq[(k / 4) % 4]);
            check("scan_kpr_q", kpr_q, 4'hF);
            check("scan_press", {3'b0, press}, 4'h0);
            check("scan_held", {3'b0, held}, 4'h0);
        end

        // 2: clean press of key (col B, row B), then 4: release with bounce
        key_down = 1'b1;
        do_reset();
        step(8);
        check("p_kpc_frozen8", kpc, 4'hB);
        step(4);
        check("p_kpc_frozen12", kpc, 4'hB);
        step(3);
        check("p_pre_kpr_q", kpr_q, 4'hF);
        check("p_pre_held", {3'b0, held}, 4'h0);
        check("p_pre_press", {3'b0, press}, 4'h0);
        step(1);
        check("p_press", {3'b0, press}, 4'h1);
        check("p_held", {3'b0, held}, 4'h1);
        check("p_kpr_q", kpr_q, 4'hB);
        check("p_kpc_q", kpc_q, 4'hB);
        step(1);
        check("p_press_end", {3'b0, press}, 4'h0);
        check("p_held_stay", {3'b0, held}, 4'h1);
        step(3);
        key_down = 1'b0;
        step(4);
        check("r_held_rel", {3'b0, held}, 4'h1);
        check("r_kpr_q_rel", kpr_q, 4'hB);
        key_down = 1'b1;
        step(4);
        check("r_held_bounce", {3'b0, held}, 4'h1);
        check("r_press_bounce", {3'b0, press}, 4'h0);
        key_down = 1'b0;
        for (int k = 29; k <= 39; k++) begin
            step(1);
            check("r_no_press", {3'b0, press}, 4'h0);
            check("r_held_wait", {3'b0, held}, 4'h1);
        end
        check("r_kpr_q_wait", kpr_q, 4'hB);
        step(1);
        check("r_kpr_q_done", kpr_q, 4'hF);
        check("r_held_done", {3'b0, held}, 4'h0);
        check("r_kpc_resume", kpc, 4'hD);
        check("r_kpc_q_keep", kpc_q, 4'hB);
        step(4);
        check("r_kpc_next", kpc, 4'hE);

        // 3: key bouncing on alternate ticks never gets accepted
        key_down = 1'b1;
        do_reset();
        for (int k = 1; k <= 48; k++) begin
            step(1);
            if (k == 12) check("b_kpc_resume", kpc, 4'hD);
            check("b_press", {3'b0, press}, 4'h0);
            check("b_held", {3'b0, held}, 4'h0);
            check("b_kpr_q", kpr_q, 4'hF);
            if (k >= 8 && k % 4 == 0) key_down = ~key_down;
        end
        key_down = 1'b0;

        // 5: two rows low is invalid, scan keeps rotating
        force_en   = 1'b1;
        force_rows = 4'b0011;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step(1);
            if (k % 4 == 0) check("m_kpc", kpc, seq[(k / 4) % 4]);
            check("m_kpr_q", kpr_q, 4'hF);
            check("m_held", {3'b0, held}, 4'h0);
        end
        force_en = 1'b0;

        // 6: reset while a key is held
        key_down = 1'b1;
        do_reset();
        step(16);
        check("h_held_before", {3'b0, held}, 4'h1);
        reset_n = 1'b0;
        #1;
        check("h_kpr_q_rst", kpr_q, 4'hF);
        check("h_held_rst", {3'b0, held}, 4'h0);
        check("h_kpc_rst", kpc, 4'h7);
        check("h_press_rst", {3'b0, press}, 4'h0);
        key_down = 1'b0;
        step(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            check("h_no_press", {3'b0, press}, 4'h0);
            check("h_no_held", {3'b0, held}, 4'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
